// File: rtl/prime_table_streamer_if.sv
// prime_table_streamer_if: load, stream, status and memory-port signals of the prime table streamer
interface prime_table_streamer_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 9
);
   logic              clear;
   logic              ld_valid;
   logic              ld_ready;
   logic [DATA_W-1:0] ld_data;
   logic              start;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   count;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;
   modport master (
      input  clear, ld_valid, ld_data, start, out_ready, mem_dout,
      output ld_ready, out_valid, out_data, out_last, busy, done, count, mem_we, mem_addr, mem_din
   );
   modport slave (
      output clear, ld_valid, ld_data, start, out_ready, mem_dout,
      input  ld_ready, out_valid, out_data, out_last, busy, done, count, mem_we, mem_addr, mem_din
   );
endinterface

// File: rtl/prime_table_streamer.sv
// prime_table_streamer: loads a table into a 1-cycle-latency block memory and streams it back over valid/ready
module prime_table_streamer #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 9
) (
   input logic clka,
   input logic rsta,
   prime_table_streamer_if.master bus
);
   typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;
   state_t            state;
   logic [ADDR_W:0]   rd_ptr;
   logic              pend, pend_last;
   logic              sk_valid, sk_last;
   logic [DATA_W-1:0] sk_data;
   logic              ld_fire, pop, issue;
   logic [1:0]        occ;
   always_comb begin
      bus.ld_ready = state == IDLE && !bus.count[ADDR_W] && !bus.start && !bus.clear;
      ld_fire      = bus.ld_ready && bus.ld_valid;
      bus.mem_we   = ld_fire && !rsta;
      bus.mem_addr = ld_fire ? bus.count[ADDR_W-1:0] : rd_ptr[ADDR_W-1:0];
      bus.mem_din  = bus.ld_data;
      pop          = bus.out_valid && bus.out_ready;
      // occupancy after this cycle's pop, so a read can be issued every cycle under continuous ready
      occ          = 2'(bus.out_valid) + 2'(sk_valid) + 2'(pend) - 2'(pop);
      issue        = state == STREAM && rd_ptr < bus.count && occ < 2'd2;
   end
   always_ff @(posedge clka) begin
      if (rsta) begin
         state         <= IDLE;
         bus.count     <= '0;
         rd_ptr        <= '0;
         pend          <= 1'b0;
         pend_last     <= 1'b0;
         sk_valid      <= 1'b0;
         sk_last       <= 1'b0;
         sk_data       <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.clear) bus.count <= '0;
               else if (bus.start) begin
                  bus.busy <= 1'b1;
                  rd_ptr   <= '0;
                  state    <= bus.count == '0 ? FINISH : STREAM;
                  bus.done <= bus.count == '0;
               end else if (ld_fire) bus.count <= bus.count + 1'b1;
            end
            STREAM: begin
               pend      <= issue;
               pend_last <= rd_ptr == bus.count - (ADDR_W+1)'(1);
               if (issue) rd_ptr <= rd_ptr + 1'b1;
               if (!bus.out_valid || pop) begin
                  if (sk_valid) begin
                     bus.out_valid <= 1'b1;
                     bus.out_data  <= sk_data;
                     bus.out_last  <= sk_last;
                     sk_valid      <= pend;
                     sk_data       <= bus.mem_dout;
                     sk_last       <= pend_last;
                  end else begin
                     bus.out_valid <= pend;
                     bus.out_last  <= pend && pend_last;
                     if (pend) bus.out_data <= bus.mem_dout;
                  end
               end else if (pend) begin
                  sk_valid <= 1'b1;
                  sk_data  <= bus.mem_dout;
                  sk_last  <= pend_last;
               end
               if (pop && bus.out_last) begin
                  state    <= FINISH;
                  bus.done <= 1'b1;
               end
            end
            FINISH: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_prime_table_streamer.sv
// tb_prime_table_streamer: randomized load/stream bench against a table model and a behavioural block memory
module tb_prime_table_streamer;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 9;
   localparam int DEPTH = 1 << ADDR_W;
   logic clk, rst;
   int checks, errors;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ref_mem [DEPTH];
   int ref_count;
   bit pat [6] = '{1, 0, 0, 1, 0, 1};
   prime_table_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
   prime_table_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clka(clk),
      .rsta(rst),
      .bus (bus.master)
   );
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
      bus.mem_dout <= mem[bus.mem_addr];
   end
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask
   task automatic load_word(input logic [DATA_W-1:0] d);
      bit acc;
      @(negedge clk);
      bus.ld_valid = 1;
      bus.ld_data = d;
      #1;
      acc = ref_count < DEPTH;
      chk("ld_ready", int'(bus.ld_ready), int'(acc));
      chk("ld_we", int'(bus.mem_we), int'(acc));
      if (acc) begin
         chk("ld_addr", int'(bus.mem_addr), ref_count);
         chk("ld_din", int'(bus.mem_din), int'(d));
         ref_mem[ref_count] = d;
         ref_count++;
      end
   endtask
   task automatic end_load;
      @(negedge clk);
      bus.ld_valid = 0;
      #1;
      chk("count", int'(bus.count), ref_count);
   endtask
   task automatic do_clear;
      @(negedge clk);
      bus.clear = 1;
      bus.ld_valid = 1;
      #1;
      chk("clr_ready", int'(bus.ld_ready), 0);
      chk("clr_we", int'(bus.mem_we), 0);
      @(posedge clk);
      #1;
      bus.clear = 0;
      bus.ld_valid = 0;
      ref_count = 0;
      chk("clr_count", int'(bus.count), 0);
   endtask
   // mode 0: ready held high, 1: random ready, 2: ready pattern 1,0,0,1,0,1 over valid cycles
   task automatic stream(input int mode, input bit ld_hold);
      int idx, k, last_hs, first_v, pi;
      bit fin, stalled;
      logic [DATA_W-1:0] held;
      idx = 0; k = 0; last_hs = 0; first_v = -1; pi = 0; fin = 0; stalled = 0; held = '0;
      @(negedge clk);
      bus.start = 1;
      bus.ld_valid = ld_hold;
      bus.ld_data = 9'h1AA;
      @(posedge clk);
      #1;
      bus.start = 0;
      while (!fin && k < 4 * ref_count + 40) begin
         @(negedge clk);
         k++;
         bus.out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : pat[pi % 6];
         if (bus.out_valid) pi++;
         #1;
         chk("strm_we", int'(bus.mem_we), 0);
         chk("strm_count", int'(bus.count), ref_count);
         if (stalled) begin
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_data", int'(bus.out_data), int'(held));
         end
         if (bus.out_valid && first_v < 0) first_v = k;
         if (bus.done) begin
            fin = 1;
            bus.ld_valid = 0;
            chk("done_idx", idx, ref_count);
            chk("done_cycle", k, ref_count == 0 ? 1 : last_hs + 1);
            chk("done_valid", int'(bus.out_valid), 0);
         end else chk("busy", int'(bus.busy), 1);
         if (bus.out_valid && bus.out_ready) begin
            if (idx < ref_count) begin
               chk("data", int'(bus.out_data), int'(ref_mem[idx]));
               chk("last", int'(bus.out_last), int'(idx == ref_count - 1));
            end else chk("extra_word", idx, ref_count - 1);
            idx++;
            last_hs = k;
         end
         stalled = bus.out_valid && !bus.out_ready;
         held = bus.out_data;
      end
      bus.ld_valid = 0;
      if (!fin) chk("timeout", 0, 1);
      if (mode == 0) chk("latency", first_v, ref_count == 0 ? -1 : 3);
      @(negedge clk);
      #1;
      chk("busy_after", int'(bus.busy), 0);
      chk("done_after", int'(bus.done), 0);
   endtask
   initial begin
      int hs, k;
      checks = 0; errors = 0; ref_count = 0;
      rst = 1;
      bus.clear = 0; bus.ld_valid = 0; bus.ld_data = '0; bus.start = 0; bus.out_ready = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.ld_valid = 1;
      #1;
      chk("rst_we", int'(bus.mem_we), 0);
      chk("rst_valid", int'(bus.out_valid), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_count", int'(bus.count), 0);
      chk("rst_data", int'(bus.out_data), 0);
      bus.ld_valid = 0;
      rst = 0;
      load_word(9'd23); load_word(9'd78); load_word(9'd5);
      end_load;
      stream(0, 0);
      stream(2, 0);
      for (int r = 0; r < 3; r++) begin
         do_clear;
         for (int i = $urandom_range(1, 40); i > 0; i--) load_word(DATA_W'($urandom));
         end_load;
         stream(1, r == 1);
      end
      do_clear;
      stream(0, 0);
      do_clear;
      for (int i = 0; i < DEPTH; i++) load_word(DATA_W'(i % 512));
      load_word(9'h55);
      end_load;
      stream(0, 0);
      do_clear;
      load_word(9'd23); load_word(9'd78); load_word(9'd5);
      end_load;
      @(negedge clk);
      bus.start = 1;
      bus.out_ready = 1;
      @(posedge clk);
      #1;
      bus.start = 0;
      hs = 0; k = 0;
      while (hs < 2 && k < 20) begin
         @(negedge clk);
         k++;
         #1;
         if (bus.out_valid && bus.out_ready) hs++;
      end
      chk("mid_hs", hs, 2);
      rst = 1;
      @(negedge clk);
      #1;
      chk("mid_valid", int'(bus.out_valid), 0);
      chk("mid_busy", int'(bus.busy), 0);
      chk("mid_done", int'(bus.done), 0);
      chk("mid_count", int'(bus.count), 0);
      rst = 0;
      ref_count = 0;
      repeat (4) begin
         @(negedge clk);
         #1;
         chk("post_done", int'(bus.done), 0);
         chk("post_valid", int'(bus.out_valid), 0);
      end
      stream(0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
